ecc_scrub_ctrl: RTL

Background scrubber for an ECC-protected SRAM whose read path is a registered `read_ecc` decode stage. The block walks every address and issues a read whenever the functional port is idle. After a fixed latency it samples the decoder result. It writes corrected data back on a single-bit error and logs multi-bit errors. It sits beside the functional requester at the SRAM port and owns the idle cycles only.

---
 rtl/ecc_scrub_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ecc_scrub_ctrl.sv
// rtl/ecc_scrub_ctrl.sv - background ECC scrubber that reads and repairs an SRAM on functional-idle cycles
module ecc_scrub_ctrl #(
    parameter int AW      = 10,
    parameter int DEPTH   = 1024,
    parameter int DBITS   = 64,
    parameter int DEC_LAT = 3,
    parameter int CW      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic [CW-1:0]    i_interval,
    input  logic             i_func_busy,
    input  logic             i_clr_counts,
    input  logic             i_dec_err_detect,
    input  logic             i_dec_err_multpl,
    input  logic [DBITS-1:0] i_dec_data,
    output logic             o_mem_rd_en,
    output logic             o_mem_wr_en,
    output logic [AW-1:0]    o_mem_addr,
    output logic [DBITS-1:0] o_mem_wr_data,
    output logic             o_busy,
    output logic [CW-1:0]    o_sbe_count,
    output logic [CW-1:0]    o_mbe_count,
    output logic             o_mbe_flag,
    output logic [AW-1:0]    o_mbe_addr,
    output logic             o_pass_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_NEXT
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] LAT_LOAD  = CW'(DEC_LAT - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    state_t             state_q, state_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      sbe_q, sbe_d;
    logic [CW-1:0]      mbe_q, mbe_d;
    logic               flag_q, flag_d;
    logic [AW-1:0]      mbe_addr_q, mbe_addr_d;
    logic [DBITS-1:0]   wr_data_q, wr_data_d;
    logic               rd_en, wr_en, pass_done, sbe_ev, mbe_ev;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        sbe_d      = sbe_q;
        mbe_d      = mbe_q;
        flag_d     = flag_q;
        mbe_addr_d = mbe_addr_q;
        wr_data_d  = wr_data_q;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        pass_done  = 1'b0;
        sbe_ev     = 1'b0;
        mbe_ev     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_enable) state_d = S_READ;
            end
            S_GAP: begin
                if (!i_enable) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_READ: begin
                // The functional requester always wins the port.
                if (!i_func_busy) begin
                    rd_en   = 1'b1;
                    cnt_d   = LAT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (i_dec_err_detect && i_dec_err_multpl) begin
                        mbe_ev     = 1'b1;
                        mbe_addr_d = ptr_q;
                        state_d    = S_NEXT;
                    end else if (i_dec_err_detect) begin
                        sbe_ev    = 1'b1;
                        wr_data_d = i_dec_data;
                        state_d   = S_WRITE;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WRITE: begin
                if (!i_func_busy) begin
                    wr_en   = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (ptr_q == LAST_ADDR) begin
                    ptr_d     = '0;
                    pass_done = 1'b1;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
                // Gap counter is loaded with interval-1 so GAP lasts exactly interval cycles.
                if (!i_enable) begin
                    state_d = S_IDLE;
                end else if (i_interval == '0) begin
                    state_d = S_READ;
                end else begin
                    cnt_d   = i_interval - CW'(1);
                    state_d = S_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (i_clr_counts) begin
            sbe_d  = '0;
            mbe_d  = '0;
            flag_d = 1'b0;
        end
        if (sbe_ev) begin
            sbe_d = i_clr_counts ? CW'(1) : ((sbe_q == CNT_MAX) ? sbe_q : sbe_q + CW'(1));
        end
        if (mbe_ev) begin
            mbe_d  = i_clr_counts ? CW'(1) : ((mbe_q == CNT_MAX) ? mbe_q : mbe_q + CW'(1));
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            sbe_q      <= '0;
            mbe_q      <= '0;
            flag_q     <= 1'b0;
            mbe_addr_q <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            sbe_q      <= sbe_d;
            mbe_q      <= mbe_d;
            flag_q     <= flag_d;
            mbe_addr_q <= mbe_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign o_mem_rd_en   = rd_en;
    assign o_mem_wr_en   = wr_en;
    assign o_mem_addr    = ptr_q;
    assign o_mem_wr_data = wr_data_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_sbe_count   = sbe_q;
    assign o_mbe_count   = mbe_q;
    assign o_mbe_flag    = flag_q;
    assign o_mbe_addr    = mbe_addr_q;
    assign o_pass_done   = pass_done;

endmodule
